// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch_stage and imem.
// master = fetch side, slave = memory side.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/gnt/rvalid, in-order prefetch queue, redirects.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          BUF_DEPTH       = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        AnyStall,
    input  logic        Jump_ID,
    input  logic [25:0] JumpTgt_ID,
    input  logic        BranchTaken_EX,
    input  logic [31:0] BranchTgt_EX,
    fetch_stage_if.master imem,
    output logic [31:0] FetchData_IF,
    output logic [31:0] PC_IF,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] PerfBubble_IF,
    output logic [31:0] PerfSquash_IF,
`endif
    output logic        Valid_IF
);

    localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = AW + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [31:0]   r_q_addr  [BUF_DEPTH];
    logic [31:0]   r_q_instr [BUF_DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_discard;
    logic [31:0]   r_fdata;
    logic [31:0]   r_pc_if;
    logic          r_valid;

    logic          w_jump;
    logic          w_redirect;
    logic          w_upd;
    logic [3:0]    w_pc_hi;
    logic [31:0]   w_target;
    logic          w_req;
    logic          w_issue;
    logic          w_drop;
    logic          w_keep;
    logic          w_empty;
    logic          w_pop;
    logic          w_bypass;
    logic          w_push;
    logic [CW-1:0] w_out_nxt;

    // Upper nibble of PC_IF+4: carry into bit 28 only when bits 27:2 are all ones
    assign w_pc_hi    = r_pc_if[31:28] + {3'b000, &r_pc_if[27:2]};
    assign w_jump     = Jump_ID & ~AnyStall;
    assign w_redirect = BranchTaken_EX | w_jump;
    assign w_upd      = ~AnyStall | BranchTaken_EX;
    assign w_target   = BranchTaken_EX ? BranchTgt_EX
                                       : {w_pc_hi, JumpTgt_ID, 2'b00};

    assign w_req = rst_n & ~w_redirect & (r_out < MAXO_C)
                 & ((r_out + r_count) < DEPTH_C);
    assign w_issue = w_req & imem.imem_gnt;

    assign w_drop   = imem.imem_rvalid & (r_discard != '0) & ~w_redirect;
    assign w_keep   = imem.imem_rvalid & (r_discard == '0) & ~w_redirect;
    assign w_empty  = (r_count == '0);
    assign w_pop    = w_upd & ~w_redirect & ~w_empty;
    assign w_bypass = w_upd & ~w_redirect & w_empty & w_keep;
    assign w_push   = w_keep & ~w_bypass;

    assign w_out_nxt = r_out + (w_issue ? ONE_C : '0)
                             - (imem.imem_rvalid ? ONE_C : '0);

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign FetchData_IF   = r_fdata;
    assign PC_IF          = r_pc_if;
    assign Valid_IF       = r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_rsp_pc  <= RESET_PC;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_out     <= '0;
            r_discard <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_q_addr[i]  <= '0;
                r_q_instr[i] <= '0;
            end
        end else begin
            r_out <= w_out_nxt;
            if (w_redirect) begin
                r_pc      <= w_target;
                r_rsp_pc  <= w_target;
                r_discard <= w_out_nxt;
                r_head    <= '0;
                r_tail    <= '0;
                r_count   <= '0;
            end else begin
                if (w_issue)
                    r_pc <= r_pc + 32'd4;
                if (w_drop)
                    r_discard <= r_discard - ONE_C;
                if (w_keep)
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                if (w_push) begin
                    r_q_addr[r_tail]  <= r_rsp_pc;
                    r_q_instr[r_tail] <= imem.imem_rdata;
                    r_tail            <= r_tail + AW'(1);
                end
                if (w_pop)
                    r_head <= r_head + AW'(1);
                r_count <= r_count + (w_push ? ONE_C : '0)
                                   - (w_pop ? ONE_C : '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fdata <= '0;
            r_pc_if <= '0;
            r_valid <= 1'b0;
        end else if (w_upd) begin
            if (w_pop) begin
                r_fdata <= r_q_instr[r_head];
                r_pc_if <= r_q_addr[r_head];
                r_valid <= 1'b1;
            end else if (w_bypass) begin
                r_fdata <= imem.imem_rdata;
                r_pc_if <= r_rsp_pc;
                r_valid <= 1'b1;
            end else begin
                r_fdata <= '0;
                r_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_bub;
    logic [31:0] r_perf_sq;
    logic        w_bubble;
    logic [32:0] w_sq_inc;
    logic [32:0] w_sq_sum;

    assign w_bubble = w_upd & ~AnyStall & ~(w_pop | w_bypass);
    // Flushed queue entries plus any response lost in this cycle
    assign w_sq_inc = {32'd0, w_drop}
                    + {32'd0, w_redirect & imem.imem_rvalid}
                    + (w_redirect ? {{(33-CW){1'b0}}, r_count} : 33'd0);
    assign w_sq_sum = {1'b0, r_perf_sq} + w_sq_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_bub <= '0;
            r_perf_sq  <= '0;
        end else begin
            if (w_bubble && (r_perf_bub != 32'hFFFF_FFFF))
                r_perf_bub <= r_perf_bub + 32'd1;
            r_perf_sq <= w_sq_sum[32] ? 32'hFFFF_FFFF : w_sq_sum[31:0];
        end
    end

    assign PerfBubble_IF = r_perf_bub;
    assign PerfSquash_IF = r_perf_sq;
`endif

endmodule
